freq_gate_counter: RTL and testbench
====================================

// Module: freq_gate_counter
// PURPOSE
//  Gated frequency counter feeding the Nios display system's freq/freq_en PIO inputs.
//  - Synchronises an asynchronous test signal and counts its rising edges over a fixed gate window.
//  - At the end of each window, publishes the count as a 32-bit value with a one-cycle valid strobe.
//  - Software reads the value and shows it on the LCD.
// PARAMETERS
//  GATE_CYCLES  50_000_000  gate window length in clk cycles (1 s at 50 MHz); must be >= 4
//  CNT_W        32          edge-counter/result width; freq output is zero-extended to 32 bits
//  SYNC_STAGES  2           flip-flop stages in the sig_in synchroniser; must be >= 2
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  sig_in       in   1   asynchronous signal under measurement
//  meas_en      in   1   1 = measure; 0 = abort current window and idle
//  freq         out  32  last completed window count (edges per gate)
//  freq_en      out  1   one-cycle strobe: freq updated this cycle
//  overflow     out  1   last published window saturated
//  gate_active  out  1   high while in MEASURE state
// BEHAVIOUR
//  - Reset values: freq=0, freq_en=0, overflow=0, gate_active=0, all counters=0, state=WARMUP.
//  - Synchroniser: SYNC_STAGES flops, then one delay flop. edge = sync & ~sync_d.
//    Maximum countable rate is clk/2.
//  - FSM states:
//    WARMUP: hold for SYNC_STAGES+1 cycles to flush the synchroniser; edges ignored.
//            Then go to IDLE.
//    IDLE: counters held at 0. Go to MEASURE on the cycle meas_en=1.
//    MEASURE: gate_cnt runs 0..GATE_CYCLES-1. Each edge increments edge_cnt,
//             saturating at 2^CNT_W-1; saturation sets ovf_flag.
//      - On the cycle gate_cnt==GATE_CYCLES-1, an edge on that cycle is counted.
//        Next cycle: freq <= final count, overflow <= ovf_flag, freq_en=1 for exactly 1 cycle.
//      - In that same last cycle, gate_cnt and edge_cnt clear and ovf_flag clears.
//        MEASURE continues back-to-back with no dead cycle, so window period = GATE_CYCLES exactly.
//      - meas_en=0 in any MEASURE cycle, including the last: window discarded, no freq_en,
//        counters cleared, go to IDLE. freq and overflow hold their previous values.
//  - gate_active = (state==MEASURE).
//  - reset mid-window: everything returns to reset values next cycle, including freq=0.
//    No strobe is issued for the partial window.
//  - Edge coincident with window rollover: belongs to the closing window.
//    The first cycle of the new window counts from 0.
// CONFIGURATION
//  FREQ_AVG4_EN defined:
//    - 4-entry history of window counts. The 34-bit running sum adds the new count
//      and drops the oldest.
//    - freq = sum>>2 (truncating). overflow = any of the 4 entries saturated.
//    - freq_en is suppressed until 4 windows have completed since IDLE/reset.
//      The history clears on IDLE and on reset.
//    - Strobe latency is unchanged: one cycle after the window ends.
//  FREQ_AVG4_EN undefined: freq = the single last window count; no history logic is synthesised.
// TESTING  (sim: GATE_CYCLES=1000, CNT_W=32 unless noted)
//  1. meas_en=1, sig_in square wave with a 10-clk period
//     -> freq_en every 1000 cycles; freq=100; overflow=0.
//  2. CNT_W=8, sig_in period 2 clk (500 edges per window) -> freq=255, overflow=1.
//     Next window at period 10 -> freq=100, overflow=0.
//  3. Single sig_in edge whose synchronised edge lands on gate_cnt==999 -> freq=1 for that window.
//     The following window gives freq=0.
//  4. meas_en drops at gate_cnt=500 -> no freq_en, freq keeps its prior value, gate_active=0 next cycle.
//     meas_en re-asserted -> full 1000-cycle window, then strobe.
//  5. reset pulsed at gate_cnt=700 while freq=100 -> freq=0, freq_en=0.
//     WARMUP lasts 3 cycles, then IDLE/MEASURE; first strobe 1000 cycles after MEASURE entry.
//  6. FREQ_AVG4_EN, windows with counts 100,100,100,104 -> first strobe only after the 4th window,
//     freq=101. Next window count 100 -> freq=101 (404/4).

Source files
------------

// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronised rising edges of sig_in over GATE_CYCLES clocks
// and publishes the count with a one-cycle strobe. Define FREQ_AVG4_EN for a 4-window moving average.
module freq_gate_counter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sig_in,
    input  logic        meas_en,
    output logic [31:0] freq,
    output logic        freq_en,
    output logic        overflow,
    output logic        gate_active,
    output logic [1:0]  dbg_state
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int WW = $clog2(SYNC_STAGES + 1);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WW-1:0]    WARM_LAST = WW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] ST_WARMUP  = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic [1:0]             r_state;
    logic [WW-1:0]          r_warm_cnt;
    logic [GW-1:0]          r_gate_cnt;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   r_ovf_flag;
    logic [CNT_W-1:0]       r_freq;
    logic                   r_ovf;
    logic                   r_freq_en;

    logic                   w_edge;
    logic                   w_last;
    logic                   w_done;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_ovf_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // An edge on the last gate cycle still lands in w_cnt_next, so it belongs to the closing window.
    always_comb begin
        w_edge     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
        w_last     = (r_gate_cnt == GATE_LAST);
        w_done     = (r_state == ST_MEASURE) && meas_en && w_last;
        w_cnt_next = r_edge_cnt;
        w_ovf_next = r_ovf_flag;
        if (w_edge) begin
            if (r_edge_cnt == CNT_MAX) w_ovf_next = 1'b1;
            else                       w_cnt_next = r_edge_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WARMUP;
            r_warm_cnt <= '0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state    <= ST_IDLE;
                        r_warm_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WW'(1);
                    end
                end
                ST_IDLE: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf_flag <= 1'b0;
                    if (meas_en) r_state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (!meas_en || w_last) begin
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_flag <= 1'b0;
                        if (!meas_en) r_state <= ST_IDLE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                        r_edge_cnt <= w_cnt_next;
                        r_ovf_flag <= w_ovf_next;
                    end
                end
                default: r_state <= ST_WARMUP;
            endcase
        end
    end

`ifdef FREQ_AVG4_EN
    logic [CNT_W-1:0] r_hist [4];
    logic [3:0]       r_hist_ovf;
    logic [CNT_W+1:0] r_sum;
    logic [2:0]       r_hist_n;
    logic [CNT_W+1:0] w_sum_next;

    assign w_sum_next = r_sum + (CNT_W+2)'(w_cnt_next) - (CNT_W+2)'(r_hist[3]);

    // History restarts whenever the FSM is idle, so averages never mix separate runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_freq    <= '0;
            r_ovf     <= 1'b0;
            r_freq_en <= 1'b0;
        end else begin
            r_freq_en <= w_done && (r_hist_n >= 3'd3);
            if (w_done && (r_hist_n >= 3'd3)) begin
                r_freq <= CNT_W'(w_sum_next >> 2);
                r_ovf  <= |{r_hist_ovf[2:0], w_ovf_next};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_IDLE)) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_hist_ovf <= '0;
            r_sum      <= '0;
            r_hist_n   <= '0;
        end else if (w_done) begin
            r_hist[0] <= w_cnt_next;
            for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
            r_hist_ovf <= {r_hist_ovf[2:0], w_ovf_next};
            r_sum      <= w_sum_next;
            if (r_hist_n != 3'd4) r_hist_n <= r_hist_n + 3'd1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_freq    <= '0;
            r_ovf     <= 1'b0;
            r_freq_en <= 1'b0;
        end else begin
            r_freq_en <= w_done;
            if (w_done) begin
                r_freq <= w_cnt_next;
                r_ovf  <= w_ovf_next;
            end
        end
    end
`endif

    assign freq        = 32'(r_freq);
    assign freq_en     = r_freq_en;
    assign overflow    = r_ovf;
    assign gate_active = (r_state == ST_MEASURE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter (GATE_CYCLES=1000, CNT_W=8): directed windows with a
// strobe scoreboard keyed on {cycle, overflow, freq}.
module tb_freq_gate_counter;

    localparam int G          = 1000;
    localparam int CW         = 8;
    localparam int PULSE_LAST = -1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_in;
    logic        meas_en;
    logic [31:0] freq;
    logic        freq_en;
    logic        overflow;
    logic        gate_active;
    logic [1:0]  dbg_state;

    freq_gate_counter #(.GATE_CYCLES(G), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
        .freq(freq), .freq_en(freq_en), .overflow(overflow),
        .gate_active(gate_active), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];

    // per-window stimulus: >0 square period, <0 burst of |v| edges, PULSE_LAST single edge at k=G-1
    int per_q[$];
    int win_base = 0;
    bit gen_on = 1'b0;
    int m, r;

    function automatic logic sig_val(int c);
        int n, k, v;
        if (!gen_on || c < win_base) return 1'b0;
        n = (c - win_base) / G;
        k = (c - win_base) % G;
        if (n >= per_q.size()) return 1'b0;
        v = per_q[n];
        if (v == PULSE_LAST) return (k == G - 1);
        if (v > 0) return (k % v) < (v / 2);
        if (v < 0) return ((k % 2) == 0) && (k < -2 * v);
        return 1'b0;
    endfunction

    initial begin
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            sig_in = sig_val(cyc);
        end
    end

    // driver tasks
    task automatic wait_slot(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    task automatic start_run(output int mm);
        int c;
        c = cyc;
        win_base = c + 1;
        gen_on = 1'b1;
        wait_slot(c + 2);
        meas_en = 1'b1;
        mm = cyc;
    endtask

    task automatic push_exp(input int c, input int f, input bit o);
        exp_q.push_back({32'(c), o, 32'(f)});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_warmup(input int rel);
        wait_slot(rel + 2);
        @(negedge clk);
        chk("warmup_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        chk("idle_after_warmup", 32'(dbg_state), 32'd1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [64:0] e;
        if (freq_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: cycle %0d freq %0d ovf %0d, required no strobe",
                         cyc, freq, overflow);
            end else begin
                e = exp_q.pop_front();
                if ({32'(cyc), overflow, freq} !== e) begin
                    errors++;
                    $display("FAIL strobe: got cycle %0d ovf %0d freq %0d, required cycle %0d ovf %0d freq %0d",
                             cyc, overflow, freq, e[64:33], e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        meas_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_freq", freq, 32'd0);
        chk("reset_freq_en", 32'(freq_en), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_gate_active", 32'(gate_active), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'd0);
        wait_slot(cyc + 1);
        reset = 1'b0;
        r = cyc;
        check_warmup(r);
        wait_slot(cyc + 2);

`ifdef FREQ_AVG4_EN
        per_q = '{-100, -100, -100, -104, -100, 10};
        start_run(m);
        push_exp(m + 4001, 101, 1'b0);
        push_exp(m + 5001, 101, 1'b0);
        wait_slot(m + 5301);
        meas_en = 1'b0;
        gen_on = 1'b0;
        wait_slot(m + 5600);
        @(negedge clk);
        chk("avg_hold_freq", freq, 32'd101);

        per_q = '{10, 10, 10, 10, 10};
        start_run(m);
        push_exp(m + 4001, 100, 1'b0);
        wait_slot(m + 4301);
        meas_en = 1'b0;
        gen_on = 1'b0;
        wait_slot(m + 4600);
        @(negedge clk);
        chk("avg_restart_freq", freq, 32'd100);
        chk("avg_restart_ovf", 32'(overflow), 32'd0);
`else
        // steady 100, saturation, recovery, last-cycle single edge, empty window, 100, then abort
        per_q = '{10, 10, 10, 2, 10, PULSE_LAST, 0, 10, 10};
        start_run(m);
        push_exp(m + 1001, 100, 1'b0);
        push_exp(m + 2001, 100, 1'b0);
        push_exp(m + 3001, 100, 1'b0);
        push_exp(m + 4001, 255, 1'b1);
        push_exp(m + 5001, 100, 1'b0);
        push_exp(m + 6001, 1, 1'b0);
        push_exp(m + 7001, 0, 1'b0);
        push_exp(m + 8001, 100, 1'b0);
        wait_slot(m + 8501);
        meas_en = 1'b0;
        @(negedge clk);
        chk("gate_active_before_abort", 32'(gate_active), 32'd1);
        @(negedge clk);
        chk("gate_active_after_abort", 32'(gate_active), 32'd0);
        gen_on = 1'b0;
        wait_slot(m + 9800);
        @(negedge clk);
        chk("abort_hold_freq", freq, 32'd100);
        chk("abort_hold_ovf", 32'(overflow), 32'd0);

        // full window after re-enable, then abort on the very last gate cycle
        wait_slot(cyc + 1);
        per_q = '{5, 10};
        start_run(m);
        push_exp(m + 1001, 200, 1'b0);
        wait_slot(m + 2000);
        meas_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("last_cycle_abort_no_strobe", 32'(freq_en), 32'd0);
        chk("last_cycle_abort_idle", 32'(gate_active), 32'd0);
        gen_on = 1'b0;
        wait_slot(m + 2300);
        @(negedge clk);
        chk("last_cycle_abort_hold_freq", freq, 32'd200);

        // reset in the middle of a window
        wait_slot(cyc + 1);
        per_q = '{10, 10};
        start_run(m);
        push_exp(m + 1001, 100, 1'b0);
        wait_slot(m + 1701);
        reset = 1'b1;
        wait_slot(m + 1702);
        reset = 1'b0;
        meas_en = 1'b0;
        gen_on = 1'b0;
        r = cyc;
        @(negedge clk);
        chk("midreset_freq", freq, 32'd0);
        chk("midreset_freq_en", 32'(freq_en), 32'd0);
        chk("midreset_gate_active", 32'(gate_active), 32'd0);
        chk("midreset_state", 32'(dbg_state), 32'd0);
        check_warmup(r);
        wait_slot(cyc + 1);
        per_q = '{4, 10};
        start_run(m);
        push_exp(m + 1001, 250, 1'b0);
        wait_slot(m + 1101);
        meas_en = 1'b0;
        gen_on = 1'b0;
        wait_slot(m + 1400);
        @(negedge clk);
        chk("post_reset_freq", freq, 32'd250);
`endif

        while (exp_q.size() > 0) begin
            logic [64:0] e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL strobe_missing: got no strobe, required cycle %0d ovf %0d freq %0d",
                     e[64:33], e[32], e[31:0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
